// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: ALU op codes, datapath widths and the
// EX-stage control bundle carried from decode into execute.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    localparam logic [3:0] ALU_AND = 4'b0011;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0100;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       alu_src;
        logic [3:0] alu_control;
    } ex_ctrl_t;

endpackage

// File: rtl/fwd_mux.sv
// Operand bypass select: EX/MEM result, then MEM/WB result, then the
// registered register-file value. x0 is never bypassed.
module fwd_mux #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] rs,
    input  logic [XLEN-1:0] reg_data,
    input  logic            exmem_reg_write,
    input  logic [RA_W-1:0] exmem_rd,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_reg_write,
    input  logic [RA_W-1:0] memwb_rd,
    input  logic [XLEN-1:0] memwb_result,
    output logic [XLEN-1:0] fwd_data
);

    logic ex_hit;
    logic wb_hit;

    assign ex_hit = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs);
    // The younger EX/MEM producer shadows MEM/WB, so the select is one-hot.
    assign wb_hit = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs)
                    && !ex_hit;

    always_comb begin
        fwd_data = reg_data;
        unique case (1'b1)
            ex_hit:  fwd_data = exmem_result;
            wb_hit:  fwd_data = memwb_result;
            default: fwd_data = reg_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use detection.
// Define ID_EX_PERF_EN to add the bubble_count performance counter.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int RA_W = riscv_pkg::RA_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic [RA_W-1:0] id_rd,
    input  logic [3:0]      id_alu_control,
    input  logic            id_alu_src,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_branch,
    input  logic            exmem_reg_write,
    input  logic [RA_W-1:0] exmem_rd,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_reg_write,
    input  logic [RA_W-1:0] memwb_rd,
    input  logic [XLEN-1:0] memwb_result,
    input  logic            stall,
    input  logic            flush,
    output logic            load_use_stall,
`ifdef ID_EX_PERF_EN
    output logic [31:0]     bubble_count,
`endif
    output logic            ex_valid,
    output logic [3:0]      ex_alu_control,
    output logic [XLEN-1:0] ex_inp1,
    output logic [XLEN-1:0] ex_inp2,
    output logic [XLEN-1:0] ex_store_data,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_imm,
    output logic [RA_W-1:0] ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_branch
);

    ex_ctrl_t        ctrl;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic            bubble;

    assign load_use_stall = ex_valid && ctrl.mem_read && (ex_rd != '0)
                            && ((ex_rd == id_rs1) || (ex_rd == id_rs2))
                            && id_valid;

    // Stall outranks the load-use bubble; flush outranks both.
    assign bubble = flush || (!stall && load_use_stall);

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid <= 1'b0;
            ctrl     <= '0;
            ex_pc    <= '0;
            ex_imm   <= '0;
            ex_rd    <= '0;
            rs1      <= '0;
            rs2      <= '0;
            rs1_data <= '0;
            rs2_data <= '0;
        end else if (bubble) begin
            ex_valid <= 1'b0;
            ctrl     <= '0;
        end else if (stall) begin
            // Latch bypassed operands so a retiring MEM/WB value survives.
            rs1_data <= fwd_rs1;
            rs2_data <= fwd_rs2;
        end else begin
            ex_valid         <= id_valid;
            ctrl.reg_write   <= id_reg_write && id_valid;
            ctrl.mem_read    <= id_mem_read && id_valid;
            ctrl.mem_write   <= id_mem_write && id_valid;
            ctrl.branch      <= id_branch && id_valid;
            ctrl.alu_src     <= id_alu_src;
            ctrl.alu_control <= id_alu_control;
            ex_pc            <= id_pc;
            ex_imm           <= id_imm;
            ex_rd            <= id_rd;
            rs1              <= id_rs1;
            rs2              <= id_rs2;
            rs1_data         <= id_rs1_data;
            rs2_data         <= id_rs2_data;
        end
    end

`ifdef ID_EX_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_count <= '0;
        end else if (bubble) begin
            bubble_count <= bubble_count + 32'd1;
        end
    end
`endif

    fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
        .rs              (rs1),
        .reg_data        (rs1_data),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .fwd_data        (fwd_rs1)
    );

    fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
        .rs              (rs2),
        .reg_data        (rs2_data),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .fwd_data        (fwd_rs2)
    );

    assign ex_alu_control = ctrl.alu_control;
    assign ex_reg_write   = ctrl.reg_write;
    assign ex_mem_read    = ctrl.mem_read;
    assign ex_mem_write   = ctrl.mem_write;
    assign ex_branch      = ctrl.branch;
    assign ex_inp1        = fwd_rs1;
    assign ex_inp2        = ctrl.alu_src ? ex_imm : fwd_rs2;
    assign ex_store_data  = fwd_rs2;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed plus randomized bench for id_ex_stage against a
// behavioural pipeline-slot model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        id_valid = 1'b0;
    logic [31:0] id_pc = '0, id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic [3:0]  id_alu_control = '0;
    logic        id_alu_src = 0, id_reg_write = 0, id_mem_read = 0;
    logic        id_mem_write = 0, id_branch = 0;
    logic        exmem_reg_write = 0, memwb_reg_write = 0;
    logic [4:0]  exmem_rd = '0, memwb_rd = '0;
    logic [31:0] exmem_result = '0, memwb_result = '0;
    logic        stall = 0, flush = 0;

    logic        load_use_stall, ex_valid;
    logic [3:0]  ex_alu_control;
    logic [31:0] ex_inp1, ex_inp2, ex_store_data, ex_pc, ex_imm;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;
`ifdef ID_EX_PERF_EN
    logic [31:0] bubble_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Model of the EX slot contents.
    logic        m_valid, m_rw, m_mr, m_mw, m_br, m_src;
    logic [3:0]  m_alu;
    logic [31:0] m_pc, m_imm, m_d1, m_d2;
    logic [4:0]  m_rd, m_rs1, m_rs2;
    logic        m_known, m_alu_known;
    logic [31:0] m_bubbles;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_alu_control(id_alu_control), .id_alu_src(id_alu_src),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_branch(id_branch),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
        .exmem_result(exmem_result), .memwb_reg_write(memwb_reg_write),
        .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .stall(stall), .flush(flush), .load_use_stall(load_use_stall),
`ifdef ID_EX_PERF_EN
        .bubble_count(bubble_count),
`endif
        .ex_valid(ex_valid), .ex_alu_control(ex_alu_control),
        .ex_inp1(ex_inp1), .ex_inp2(ex_inp2), .ex_store_data(ex_store_data),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_branch(ex_branch)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mfwd(logic [4:0] rs, logic [31:0] d);
        if (exmem_reg_write && exmem_rd != 0 && exmem_rd == rs)
            return exmem_result;
        if (memwb_reg_write && memwb_rd != 0 && memwb_rd == rs)
            return memwb_result;
        return d;
    endfunction

    function automatic logic m_lus();
        return m_valid && m_mr && m_rd != 0 &&
               (m_rd == id_rs1 || m_rd == id_rs2) && id_valid;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        #1;
        chk({tag, ".valid"}, ex_valid, m_valid);
        chk({tag, ".rw"}, ex_reg_write, m_rw);
        chk({tag, ".mr"}, ex_mem_read, m_mr);
        chk({tag, ".mw"}, ex_mem_write, m_mw);
        chk({tag, ".br"}, ex_branch, m_br);
        chk({tag, ".lus"}, load_use_stall, m_lus());
        if (m_alu_known) chk({tag, ".alu"}, ex_alu_control, m_alu);
        if (m_known) begin
            chk({tag, ".pc"}, ex_pc, m_pc);
            chk({tag, ".imm"}, ex_imm, m_imm);
            chk({tag, ".rd"}, ex_rd, m_rd);
            chk({tag, ".inp1"}, ex_inp1, mfwd(m_rs1, m_d1));
            chk({tag, ".inp2"}, ex_inp2, m_src ? m_imm : mfwd(m_rs2, m_d2));
            chk({tag, ".sd"}, ex_store_data, mfwd(m_rs2, m_d2));
        end
`ifdef ID_EX_PERF_EN
        chk({tag, ".bcnt"}, bubble_count, m_bubbles);
`endif
    endtask

    // Advance the model by the rules for one edge, then clock the DUT.
    task automatic tick();
        logic lus;
        lus = m_lus();
        if (reset) begin
            {m_valid, m_rw, m_mr, m_mw, m_br, m_src} = '0;
            m_alu = '0; m_pc = '0; m_imm = '0; m_d1 = '0; m_d2 = '0;
            m_rd = '0; m_rs1 = '0; m_rs2 = '0;
            m_known = 1; m_alu_known = 1; m_bubbles = '0;
        end else if (flush || (!stall && lus)) begin
            {m_valid, m_rw, m_mr, m_mw, m_br} = '0;
            m_alu = '0; m_alu_known = 1; m_known = 0;
            m_bubbles = m_bubbles + 1;
        end else if (stall) begin
            m_d1 = mfwd(m_rs1, m_d1);
            m_d2 = mfwd(m_rs2, m_d2);
        end else begin
            m_valid = id_valid;
            m_rw = id_reg_write & id_valid;
            m_mr = id_mem_read & id_valid;
            m_mw = id_mem_write & id_valid;
            m_br = id_branch & id_valid;
            m_src = id_alu_src; m_alu = id_alu_control;
            m_pc = id_pc; m_imm = id_imm; m_rd = id_rd;
            m_rs1 = id_rs1; m_rs2 = id_rs2;
            m_d1 = id_rs1_data; m_d2 = id_rs2_data;
            m_known = 1; m_alu_known = id_valid;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc,
                          input logic [4:0] r1, input logic [31:0] d1,
                          input logic [4:0] r2, input logic [31:0] d2,
                          input logic [4:0] rd, input logic [3:0] alu,
                          input logic rw, input logic mr);
        id_valid = v; id_pc = pc; id_rs1 = r1; id_rs1_data = d1;
        id_rs2 = r2; id_rs2_data = d2; id_rd = rd; id_alu_control = alu;
        id_imm = 32'h40; id_alu_src = 0; id_reg_write = rw;
        id_mem_read = mr; id_mem_write = 0; id_branch = 0;
    endtask

    logic [3:0] ops [4];

    initial begin
        ops[0] = 4'b0011; ops[1] = 4'b0001;
        ops[2] = 4'b0010; ops[3] = 4'b0100;
        m_valid = 0; m_known = 0; m_alu_known = 0; m_bubbles = '0;
        {m_rw, m_mr, m_mw, m_br, m_src} = '0;
        @(negedge clk);
        tick();
        tick();
        reset = 0;
        check_all("reset");
        chk("reset.inp1", ex_inp1, 32'h0);

        set_id(1, 32'h100, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 4'b0010, 1, 0);
        tick();
        check_all("add");
        chk("add.inp1", ex_inp1, 32'd5);
        chk("add.inp2", ex_inp2, 32'd7);
        chk("add.alu", ex_alu_control, 4'b0010);
        chk("add.valid", ex_valid, 1'b1);

        set_id(1, 32'h104, 5'd3, 32'h1, 5'd2, 32'h2, 5'd7, 4'b0001, 1, 0);
        tick();
        id_valid = 0;
        exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'hAA;
        memwb_reg_write = 1; memwb_rd = 3; memwb_result = 32'hBB;
        check_all("fwd_ex");
        chk("fwd_ex.inp1", ex_inp1, 32'hAA);
        exmem_reg_write = 0;
        check_all("fwd_wb");
        chk("fwd_wb.inp1", ex_inp1, 32'hBB);
        exmem_reg_write = 1; exmem_rd = 0; memwb_rd = 0;
        set_id(1, 32'h108, 5'd0, 32'h11, 5'd2, 32'h2, 5'd7, 4'b0011, 1, 0);
        tick();
        check_all("fwd_x0");
        chk("fwd_x0.inp1", ex_inp1, 32'h11);
        exmem_reg_write = 0; memwb_reg_write = 0;

        set_id(1, 32'h10c, 5'd1, 32'h0, 5'd2, 32'h0, 5'd4, 4'b0010, 1, 1);
        tick();
        set_id(1, 32'h110, 5'd5, 32'h3, 5'd4, 32'h9, 5'd8, 4'b0100, 1, 0);
        check_all("lu");
        chk("lu.lus", load_use_stall, 1'b1);
        tick();
        check_all("lu_bub");
        chk("lu_bub.valid", ex_valid, 1'b0);
        chk("lu_bub.rw", ex_reg_write, 1'b0);
`ifdef ID_EX_PERF_EN
        chk("lu_bub.bcnt", bubble_count, 32'd1);
`endif

        set_id(1, 32'h200, 5'd6, 32'h10, 5'd1, 32'h20, 5'd9, 4'b0001, 1, 0);
        tick();
        memwb_reg_write = 1; memwb_rd = 6; memwb_result = 32'h55;
        stall = 1;
        set_id(1, 32'h300, 5'd9, 32'h1, 5'd10, 32'h2, 5'd11, 4'b0011, 1, 0);
        check_all("st0");
        tick();
        check_all("st1");
        tick();
        memwb_reg_write = 0;
        check_all("st2");
        chk("st2.inp1", ex_inp1, 32'h55);
        chk("st2.pc", ex_pc, 32'h200);
        stall = 0;

        tick();
        flush = 1; stall = 1;
        tick();
        flush = 0; stall = 0;
        check_all("fl_st");
        chk("fl_st.valid", ex_valid, 1'b0);

        set_id(1, 32'h400, 5'd1, 32'h7, 5'd2, 32'h8, 5'd5, 4'b0010, 1, 0);
        tick();
        reset = 1;
        tick();
        reset = 0;
        id_valid = 0;
        check_all("mid_rst");
        chk("mid_rst.valid", ex_valid, 1'b0);
        chk("mid_rst.pc", ex_pc, 32'h0);
        chk("mid_rst.rw", ex_reg_write, 1'b0);

        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            flush = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 5) == 0);
            id_valid = ($urandom_range(0, 4) != 0);
            id_pc = $urandom; id_imm = $urandom;
            id_rs1_data = $urandom; id_rs2_data = $urandom;
            id_rs1 = 5'($urandom_range(0, 7));
            id_rs2 = 5'($urandom_range(0, 7));
            id_rd = 5'($urandom_range(0, 7));
            id_alu_control = ops[$urandom_range(0, 3)];
            id_alu_src = 1'($urandom);
            id_reg_write = 1'($urandom);
            id_mem_read = ($urandom_range(0, 2) == 0);
            id_mem_write = 1'($urandom);
            id_branch = 1'($urandom);
            exmem_reg_write = 1'($urandom);
            exmem_rd = 5'($urandom_range(0, 7));
            exmem_result = $urandom;
            memwb_reg_write = 1'($urandom);
            memwb_rd = 5'($urandom_range(0, 7));
            memwb_result = $urandom;
            check_all("rnd");
            tick();
        end
        reset = 0;
        check_all("rnd_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register feeding the ALU (alu_control, inp1, inp2).
- Registers decoded operands and control, forwards results from EX/MEM and MEM/WB onto the ALU inputs, and detects load-use hazards.
- Supports bubble insertion, flush and downstream stall.

Parameters:
- XLEN, 32, datapath width
- RA_W, 5, register address width

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- id_valid  in  1  decode slot holds a real instruction
- id_pc  in  XLEN  instruction PC
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_imm  in  XLEN  sign-extended immediate
- id_rs1, id_rs2, id_rd  in  RA_W  register addresses
- id_alu_control  in  4  ALU op code
- id_alu_src  in  1  1 = inp2 takes imm
- id_reg_write, id_mem_read, id_mem_write, id_branch  in  1  control bits
- exmem_reg_write  in  1  EX/MEM writes rd
- exmem_rd  in  RA_W  EX/MEM destination register
- exmem_result  in  XLEN  EX/MEM result
- memwb_reg_write  in  1  MEM/WB writes rd
- memwb_rd  in  RA_W  MEM/WB destination register
- memwb_result  in  XLEN  MEM/WB result
- stall  in  1  downstream hold
- flush  in  1  branch-taken kill
- load_use_stall  out  1  decode/fetch must hold
- ex_valid  out  1  EX slot valid
- ex_alu_control  out  4  to ALU alu_control
- ex_inp1, ex_inp2  out  XLEN  to ALU inp1/inp2
- ex_store_data  out  XLEN  forwarded rs2
- ex_pc, ex_imm  out  XLEN  registered copies
- ex_rd  out  RA_W  registered destination
- ex_reg_write, ex_mem_read, ex_mem_write, ex_branch  out  1  registered control

Behaviour:
- Reset: every registered output 0; ex_valid=0; ex_alu_control=4'b0000.
- Latency: 1 cycle, decode inputs at edge N appear on ex_* after edge N.
- Per-edge priority: reset > flush > stall > load_use_stall > load.
- flush: bubble. ex_valid, reg_write, mem_read, mem_write, branch cleared; alu_control=0; data fields don't-care. Flush wins over simultaneous stall.
- stall (no flush): all EX registers hold, except rs1/rs2 data registers, which capture the current forwarded operand values. This prevents losing a forward when MEM/WB retires during the hold.
- load_use_stall (combinational):
  - asserted when ex_valid & ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2) & id_valid.
  - next edge inserts a bubble, as for flush.
- load: all id_* captured; ex_valid=id_valid. Invalid instructions load with control bits forced 0.
- Forwarding (combinational on registered rs1/rs2), evaluated per operand:
  - if exmem_reg_write & exmem_rd!=0 & exmem_rd==rs, use exmem_result;
  - else if memwb_reg_write & memwb_rd!=0 & memwb_rd==rs, use memwb_result;
  - else use the registered data.
  - EX/MEM has priority. x0 is never forwarded.
- ALU operands:
  - ex_inp1 = fwd_rs1.
  - ex_inp2 = ex_alu_src ? ex_imm : fwd_rs2.
  - ex_store_data = fwd_rs2 always.
- ALU encoding: 0011 AND, 0001 OR, 0010 ADD, 0100 SUB. Passed through unchanged; no validity check here.

Optional Feature:
- ID_EX_PERF_EN defined:
  - adds output bubble_count[31:0], reset 0.
  - increments on each edge a bubble is inserted (flush or load_use_stall, not masked by stall).
  - wraps 0xFFFFFFFF->0.
- ID_EX_PERF_EN undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package riscv_pkg:
  - ALU op constants ALU_AND=4'b0011, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0100
  - XLEN, RA_W
  - ex_ctrl_t struct (reg_write, mem_read, mem_write, branch, alu_src, alu_control)
- One sub-module: fwd_mux. Instantiated twice; inputs rs addr, reg data, both bypass tuples; output forwarded value.

Test Plan:
- Reset then load ADD (pc=0x100, rs1_data=5, rs2_data=7, alu_src=0) -> next cycle ex_inp1=5, ex_inp2=7, ex_alu_control=0010, ex_valid=1.
- exmem_rd=3, exmem_result=0xAA and memwb_rd=3, memwb_result=0xBB, ex rs1=3 -> ex_inp1=0xAA. With exmem_reg_write=0 -> 0xBB. With rs1=0 -> registered value.
- EX holds lw rd=4; decode rs2=4 -> load_use_stall=1 same cycle. Next cycle ex_valid=0, ex_reg_write=0; bubble_count=1 if enabled.
- stall=1 for 2 cycles while memwb forwards 0x55 to rs1, then memwb_reg_write drops -> ex_inp1 stays 0x55 and ex_* otherwise unchanged.
- flush=1 and stall=1 together -> bubble inserted; ex_valid=0.
- reset asserted mid-stream with valid instruction in EX -> all outputs 0 next edge.
